dpram_be: RTL
=============

# dpram_be

Parametrised dual-port synchronous RAM for the arcade cores: two symmetric read/write ports on one clock, byte-lane write enables, selectable same-port read-during-write behaviour, and a hardware clear engine that fills the array with a fixed value after reset or on request. It replaces the fixed 8-bit dual-port and single-port RAMs used for work RAM, video RAM and palette memories. A download loader or CPU connects to either port.

## Interface
- AW, 8, address width; depth = 2**AW words
- DW, 8, data width; multiple of 8; NB = DW/8 byte lanes
- RDW, 0, same-port read-during-write: 0 = od holds previous value, 1 = od returns newly written word
- IV, 0, clear value (DW bits) written by the clear engine
- CLR, 1, 1 = clear engine runs after reset; 0 = no clear after reset, array contents undefined

- cl  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- clr  in  1  clear request pulse; honoured only while idle
- busy  out  1  clear engine active; port accesses ignored
- ad0 / ad1  in  AW  port 0 / port 1 address
- en0 / en1  in  1  port access enable
- wr0 / wr1  in  1  write (1) or read (0), qualified by en
- be0 / be1  in  NB  byte-lane write enables; bit i covers data bits [8i+7:8i]
- id0 / id1  in  DW  write data
- od0 / od1  out  DW  registered read data

## Operation
- FSM states IDLE and CLEAR, with counter cnt[AW-1:0].
- While rst is high: state = CLEAR if CLR=1, else IDLE; cnt = 0; od0 = od1 = 0; busy = CLR. Nothing is written to the array.
- CLEAR, rst low: each cycle write IV to core[cnt], then cnt++. In the cycle that writes address 2**AW-1, state goes to IDLE and busy goes to 0. cnt wraps to 0.
- IDLE with clr = 1: state goes to CLEAR, busy goes to 1, cnt = 0. Any port access in that same cycle is still performed. clr during CLEAR is ignored.
- rst during CLEAR restarts the clear from address 0.
- While busy = 1, port enables are ignored: no writes, and od0/od1 hold their value.
- Port read (en=1, wr=0): od <= core[ad].
- Port write (en=1, wr=1): each lane with be[i]=1 is written from id. Lanes with be[i]=0 keep their content. wr with be = 0 writes nothing.
  - RDW=0: od holds.
  - RDW=1: od <= merged word, i.e. new lanes from id and old lanes from core.
- Both ports write the same address in one cycle: port 1 wins on each lane both enable. Lanes enabled by only one port take that port's data.
- Cross-port read of an address written in the same cycle returns the old content.

## Timing
- Read latency is 1 clock: address at edge n, data on od at edge n; valid after n until the next access.
- Write takes effect at edge n. A read of that address on either port at edge n+1 returns the new data.
- Clear duration is exactly 2**AW clocks after the first cycle with rst low or after clr is accepted. busy reads 1 for exactly those clocks (plus the rst-high cycles).
- The first accepted access is in the first cycle where busy = 0.
- Reset values: od0 = od1 = 0; busy = CLR; state and cnt as above.
- No combinational path from inputs to outputs.

## Test plan
- AW=4, DW=16, IV=16'hA5A5, CLR=1: hold rst 3 clocks, release. busy stays high for 16 clocks, then drops. A read of all 16 addresses returns A5A5.
- Byte lanes: write 16'h1234 at addr 3 with be=2'b01, then read. od0 = 16'hA534. Then write 16'hBEEF with be=2'b10; read on port 1 gives 16'hBE34.
- Collision: at addr 7, port 0 writes 16'h1111 with be=11 and port 1 writes 16'h2222 with be=10 in the same cycle. A later read gives 16'h2211.
- RDW: write 16'hCAFE at addr 2 on port 0. With RDW=0, od0 keeps its prior value. With RDW=1, od0 = CAFE one clock later. A port 1 read of addr 2 in the same cycle returns the old word.
- Mid-clear reset: pulse rst at clear cycle 5. The clear restarts and busy lasts 16 more clocks. Writes attempted while busy are lost, and od is unchanged.
- clr pulse in IDLE after data is written: busy is high 16 clocks, all words read IV, and clr asserted while busy has no effect on duration.

Source files
------------

// File: rtl/dpram_be.sv
// Dual-port synchronous RAM with byte-lane write enables, selectable
// same-port read-during-write and a fill-on-reset/request clear engine.
module dpram_be #(
  parameter int unsigned   AW  = 8,
  parameter int unsigned   DW  = 8,
  parameter int unsigned   RDW = 0,
  parameter logic [DW-1:0] IV  = '0,
  parameter int unsigned   CLR = 1
) (
  input  logic              cl,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  input  logic [AW-1:0]     ad0,
  input  logic [AW-1:0]     ad1,
  input  logic              en0,
  input  logic              en1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [DW/8-1:0]   be0,
  input  logic [DW/8-1:0]   be1,
  input  logic [DW-1:0]     id0,
  input  logic [DW-1:0]     id1,
  output logic [DW-1:0]     od0,
  output logic [DW-1:0]     od1
);

  localparam int unsigned NB    = DW / 8;
  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_cnt;
  logic [DW-1:0]   r_core [DEPTH];

  logic            w_idle;
  logic            w_wr0;
  logic            w_wr1;
  logic [DW-1:0]   w_merge0;
  logic [DW-1:0]   w_merge1;

  // Clear sequencer: walks every address once, then returns to idle.
  always_ff @(posedge cl) begin
    if (rst) begin
      r_state <= (CLR != 0) ? S_CLEAR : S_IDLE;
      r_cnt   <= '0;
      busy    <= (CLR != 0);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clr) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            busy    <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (&r_cnt) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign w_idle = (r_state == S_IDLE) && !rst;
  assign w_wr0  = w_idle && en0 && wr0;
  assign w_wr1  = w_idle && en1 && wr1;

  // Word as it will look after this port's own lane write.
  always_comb begin
    w_merge0 = r_core[ad0];
    w_merge1 = r_core[ad1];
    for (int i = 0; i < NB; i++) begin
      if (be0[i]) w_merge0[8*i +: 8] = id0[8*i +: 8];
      if (be1[i]) w_merge1[8*i +: 8] = id1[8*i +: 8];
    end
  end

  // Array update; port 1 is applied last so it wins shared lanes.
  always_ff @(posedge cl) begin
    if (!rst) begin
      if (r_state == S_CLEAR) begin
        r_core[r_cnt] <= IV;
      end else begin
        for (int i = 0; i < NB; i++) begin
          if (w_wr0 && be0[i]) r_core[ad0][8*i +: 8] <= id0[8*i +: 8];
        end
        for (int i = 0; i < NB; i++) begin
          if (w_wr1 && be1[i]) r_core[ad1][8*i +: 8] <= id1[8*i +: 8];
        end
      end
    end
  end

  // Registered read data; cross-port reads see the pre-write content.
  always_ff @(posedge cl) begin
    if (rst) begin
      od0 <= '0;
      od1 <= '0;
    end else if (w_idle) begin
      if (en0) begin
        if (!wr0)          od0 <= r_core[ad0];
        else if (RDW != 0) od0 <= w_merge0;
      end
      if (en1) begin
        if (!wr1)          od1 <= r_core[ad1];
        else if (RDW != 0) od1 <= w_merge1;
      end
    end
  end

endmodule
